iob_sram_ctrl: RTL and testbench

IOb slave that serves single-word IOb requests from a single-port synchronous SRAM. It sits directly downstream of the Wishbone-to-IOb bridge and consumes its `valid/address/wdata/wstrb` request, answering with a registered one-cycle `ready_o` pulse and read data. A programmable number of wait states accommodates slow or registered-output SRAM macros. Every transaction, read or write, has the same fixed latency.

---
 rtl/iob_sram_ctrl_if.sv | 33 +++
 rtl/iob_sram_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_iob_sram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_sram_ctrl_if.sv
// IOb request/response bus between the Wishbone-to-IOb bridge (master)
// and the SRAM controller (slave).
interface iob_sram_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  valid_i;
  logic [ADDR_W-1:0]     address_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [DATA_W/8-1:0]   wstrb_i;
  logic [DATA_W-1:0]     rdata_o;
  logic                  ready_o;

  modport master (
    output valid_i,
    output address_i,
    output wdata_i,
    output wstrb_i,
    input  rdata_o,
    input  ready_o
  );

  modport slave (
    input  valid_i,
    input  address_i,
    input  wdata_i,
    input  wstrb_i,
    output rdata_o,
    output ready_o
  );

endinterface

// File: rtl/iob_sram_ctrl.sv
// IOb slave serving single-word requests from a single-port synchronous
// SRAM. Every transaction takes a fixed 4+WAIT_STATES cycles:
// IDLE (capture) -> ACCESS -> WAIT x WAIT_STATES -> LATCH -> RESP.
// All outputs are registered; ready has no combinational path from valid,
// since the upstream bridge gates its valid with ready.
module iob_sram_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  iob_sram_ctrl_if.slave        iob,
  output logic                  mem_en_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int STRB_W = DATA_W / 8;
  // Byte offset bits within one data word.
  localparam int OFF = $clog2(STRB_W);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_LATCH  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_s;
  logic                  capture_s;

  // Registered request.
  logic [MEM_ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [STRB_W-1:0]     strb_r;

  // Registered SRAM strobes and response.
  logic                  en_r;
  logic [STRB_W-1:0]     we_r;
  logic                  en_s;
  logic [STRB_W-1:0]     we_s;
  logic                  ready_r;
  logic                  ready_s;
  logic [DATA_W-1:0]     rdata_r;
  logic                  latch_s;

  // Word address: low byte-offset bits dropped, upper bits alias.
  logic [MEM_ADDR_W-1:0] word_s;
  assign word_s = iob.address_i[MEM_ADDR_W+OFF-1:OFF];

  // Address bits that do not take part in word selection.
  logic unused_lo;
  assign unused_lo = ^iob.address_i[OFF-1:0];

  if (ADDR_W > MEM_ADDR_W + OFF) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^iob.address_i[ADDR_W-1:MEM_ADDR_W+OFF];
  end

  // Next-state, wait counter and request-capture decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (iob.valid_i) begin
          capture_s = 1'b1;
          cnt_s     = WAIT_INIT;
          state_s   = S_ACCESS;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (WAIT_INIT != 4'd0) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_LATCH;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        // Leaving on a count of 1 yields exactly WAIT_STATES cycles here;
        // the <= also guards against a corrupted zero count.
        if (cnt_r <= 4'd1) begin
          state_s = S_LATCH;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_LATCH: begin
        state_s = S_RESP;
      end
      S_RESP: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Output next-values: SRAM strobes only in the cycle after capture,
  // ready in the cycle after LATCH.
  always_comb begin
    en_s    = 1'b0;
    we_s    = '0;
    ready_s = 1'b0;
    latch_s = 1'b0;
    if (capture_s) begin
      en_s = 1'b1;
      we_s = iob.wstrb_i;
    end else begin
      en_s = 1'b0;
      we_s = '0;
    end
    if (state_r == S_LATCH) begin
      ready_s = 1'b1;
      latch_s = 1'b1;
    end else begin
      ready_s = 1'b0;
      latch_s = 1'b0;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request capture; address/data keep driving the SRAM after ACCESS.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_r  <= '0;
      wdata_r <= '0;
      strb_r  <= '0;
    end else if (capture_s) begin
      addr_r  <= word_s;
      wdata_r <= iob.wdata_i;
      strb_r  <= iob.wstrb_i;
    end
  end

  // SRAM enable and byte write enables, high for the ACCESS cycle only.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      en_r <= 1'b0;
      we_r <= '0;
    end else begin
      en_r <= en_s;
      we_r <= we_s;
    end
  end

  // Response: ready pulse during RESP; read data captured in LATCH
  // (zero for writes) and held until the next LATCH.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ready_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      ready_r <= ready_s;
      if (latch_s) begin
        rdata_r <= (strb_r == '0) ? mem_rdata_i : '0;
      end
    end
  end

  assign mem_en_o    = en_r;
  assign mem_we_o    = we_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign iob.ready_o = ready_r;
  assign iob.rdata_o = rdata_r;

endmodule

// File: tb/tb_iob_sram_ctrl.sv
// Scoreboard bench for iob_sram_ctrl. Three instances (WAIT_STATES 0, 3
// and 15) each get a behavioural SRAM, a reference word array, a driver
// that pushes expected responses, and a monitor that pops and compares.
module tb_iob_sram_ctrl;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic [9:0]  word;
    logic [3:0]  we;
    logic [31:0] wdata;
  } exp_t;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 15);

    logic        rst_n;
    logic        en;
    logic [3:0]  we;
    logic [9:0]  maddr;
    logic [31:0] mwdata;
    logic [31:0] mrdata;
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] sram [1024];
    logic        done;
    exp_t        q [$];

    iob_sram_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    iob_sram_ctrl #(
      .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_STATES(W)
    ) dut (
      .clk_i       (clk),
      .arst_n_i    (rst_n),
      .iob         (bus),
      .mem_en_o    (en),
      .mem_we_o    (we),
      .mem_addr_o  (maddr),
      .mem_wdata_o (mwdata),
      .mem_rdata_i (mrdata)
    );

    // Synchronous SRAM model with a backdoor preload port.
    always @(posedge clk) begin
      if (pre_we) begin
        sram[pre_addr] <= pre_data;
      end else if (en) begin
        for (int b = 0; b < 4; b++)
          if (we[b]) sram[maddr][8*b +: 8] <= mwdata[8*b +: 8];
        if (we == 4'd0) mrdata <= sram[maddr];
        else            mrdata <= 32'hFFFF_FFFF;
      end
    end

    // Monitor: SRAM strobe sanity every cycle, scoreboard pop on ready.
    initial begin
      int          en_cnt;
      logic [9:0]  last_addr;
      logic [3:0]  last_we;
      logic [31:0] last_wdata;
      exp_t        e;
      en_cnt = 0;
      last_addr = 10'd0;
      last_we = 4'd0;
      last_wdata = 32'd0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          en_cnt = 0;
        end else begin
          checks++;
          if (we !== 4'd0 && en !== 1'b1) begin
            errors++;
            $display("FAIL we_without_en W=%0d cyc=%0d we=%b en=%b required we=0000", W, cyc, we, en);
          end
          if (en === 1'b1) begin
            en_cnt++;
            last_addr = maddr;
            last_we = we;
            last_wdata = mwdata;
          end
          if (bus.ready_o === 1'b1) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ready W=%0d cyc=%0d got ready=1 required no response", W, cyc);
            end else begin
              e = q.pop_front();
              checks++;
              if (cyc != e.cyc) begin
                errors++;
                $display("FAIL latency W=%0d got ready at cyc %0d required cyc %0d", W, cyc, e.cyc);
              end
              checks++;
              if (bus.rdata_o !== e.rdata) begin
                errors++;
                $display("FAIL rdata W=%0d cyc=%0d got %h required %h", W, cyc, bus.rdata_o, e.rdata);
              end
              checks++;
              if (en_cnt != 1 || last_addr !== e.word || last_we !== e.we ||
                  (e.we != 4'd0 && last_wdata !== e.wdata)) begin
                errors++;
                $display("FAIL sram_access W=%0d cyc=%0d got en_cnt=%0d addr=%0d we=%b wdata=%h required 1/%0d/%b/%h",
                         W, cyc, en_cnt, last_addr, last_we, last_wdata, e.word, e.we, e.wdata);
              end
            end
            en_cnt = 0;
          end
        end
      end
    end

    // Driver plus reference model: directed table, mid-transaction reset,
    // then randomized traffic.
    initial begin
      logic [31:0] ref_mem [32];
      logic [31:0] d_addr  [9] = '{32'h14, 32'h08, 32'h08, 32'h14, 32'h14,
                                    32'h1000, 32'h0, 32'h1C, 32'h1C};
      logic [3:0]  d_strb  [9] = '{4'h0, 4'b0101, 4'h0, 4'h0, 4'h0,
                                    4'hF, 4'h0, 4'hF, 4'h0};
      logic [31:0] d_wdata [9] = '{32'h0, 32'hAABB_CCDD, 32'h0, 32'h0, 32'h0,
                                    32'hCAFE_F00D, 32'h0, 32'h5A5A_1234, 32'h0};
      int          d_gap   [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 2};
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      logic [9:0]  word;
      logic [31:0] d;
      int          gap;
      int          t;
      exp_t        e;

      done = 1'b0;
      rst_n = 1'b0;
      pre_we = 1'b0;
      pre_addr = 10'd0;
      pre_data = 32'd0;
      bus.valid_i = 1'b0;
      bus.address_i = 32'd0;
      bus.wdata_i = 32'd0;
      bus.wstrb_i = 4'd0;

      for (int i = 0; i < 32; i++) begin
        d = (i == 5) ? 32'hDEAD_BEEF : ((i == 2) ? 32'h1122_3344 : $urandom);
        ref_mem[i] = d;
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = 10'(i);
        pre_data = d;
      end
      @(negedge clk);
      pre_we = 1'b0;

      checks++;
      if ({bus.ready_o, bus.rdata_o, en, we, maddr, mwdata} !== 80'd0) begin
        errors++;
        $display("FAIL reset_state W=%0d got ready=%b rdata=%h en=%b we=%b addr=%0d wdata=%h required all 0",
                 W, bus.ready_o, bus.rdata_o, en, we, maddr, mwdata);
      end

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int n = 0; n < 49; n++) begin
        if (n < 9) begin
          addr = d_addr[n];
          strb = d_strb[n];
          wd = d_wdata[n];
          gap = d_gap[n];
        end else begin
          addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
          strb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
          wd = $urandom;
          gap = $urandom_range(0, 2);
        end
        word = addr[11:2];

        bus.address_i = addr;
        bus.wdata_i = wd;
        bus.wstrb_i = strb;
        bus.valid_i = 1'b1;

        e.cyc = cyc + 3 + W;
        e.word = word;
        e.we = strb;
        e.wdata = wd;
        if (strb == 4'd0) begin
          e.rdata = ref_mem[word[4:0]];
        end else begin
          e.rdata = 32'd0;
          for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[word[4:0]][8*b +: 8] = wd[8*b +: 8];
        end
        if (n != 7) q.push_back(e);

        @(posedge clk);
        #1;

        if (n == 7) begin
          // Reset in the LATCH cycle; the write already hit the SRAM.
          bus.valid_i = 1'b0;
          repeat (1 + W) begin
            @(posedge clk);
            #1;
          end
          rst_n = 1'b0;
          #1;
          checks++;
          if ({bus.ready_o, bus.rdata_o, en, we, maddr, mwdata} !== 80'd0) begin
            errors++;
            $display("FAIL reset_mid W=%0d got ready=%b rdata=%h en=%b we=%b addr=%0d wdata=%h required all 0",
                     W, bus.ready_o, bus.rdata_o, en, we, maddr, mwdata);
          end
          repeat (2) @(posedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          repeat (6 + W) @(posedge clk);
          #1;
        end else begin
          t = 0;
          while (bus.ready_o !== 1'b1 && t < 40) begin
            bus.valid_i = 1'($urandom_range(0, 1));
            bus.address_i = $urandom;
            bus.wdata_i = $urandom;
            bus.wstrb_i = 4'($urandom);
            @(posedge clk);
            #1;
            t++;
          end
          checks++;
          if (t >= 40) begin
            errors++;
            $display("FAIL ready_timeout W=%0d txn=%0d got no ready in 40 cycles required ready", W, n);
          end
          bus.valid_i = 1'b0;
          @(posedge clk);
          #1;
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
        end
      end

      t = 0;
      while (q.size() != 0 && t < 40) begin
        @(posedge clk);
        t++;
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain W=%0d got %0d responses outstanding required 0", W, q.size());
      end
      done = 1'b1;
    end
  end

  // Termination: wait for all three drivers, bounded.
  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].done === 1'b1 && g_inst[1].done === 1'b1 && g_inst[2].done === 1'b1)
           && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) begin
      errors++;
      $display("FAIL global_timeout got drivers unfinished required all done");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
